// File: rtl/result_serializer.sv
// result_serializer: FIFO-buffered MSB-first bit serializer for result words with a set-completion pulse
module result_serializer #(
    parameter int DATA_W = 20,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] res_data,
    input  logic              res_last,
    output logic              res_ready,
    output logic              out_valid,
    output logic              out_value,
    output logic              done
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DATA_W);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  mem_last_q;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
    logic              cur_last_q, cur_last_d, done_q, done_d;
    logic              push, pop;

    // rst_n is active-high; all outputs are held quiet while it is asserted
    assign res_ready = !rst_n && (count_q < FULL);
    assign out_valid = !rst_n && (state_q == SHIFT);
    assign out_value = out_valid && shift_q[DATA_W-1];
    assign done      = !rst_n && done_q;

    // Next state: load a new word whenever idle or on the last bit, so words stream without gaps
    always_comb begin
        push       = res_valid && res_ready;
        pop        = (count_q != '0) && (state_q == IDLE || bit_cnt_q == '0);
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        cur_last_d = cur_last_q;
        done_d     = (state_q == SHIFT) && (bit_cnt_q == '0) && cur_last_q;
        wr_ptr_d   = wr_ptr_q + AW'(push);
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        count_d    = count_q + (AW+1)'(push) - (AW+1)'(pop);
        if (pop) begin
            state_d    = SHIFT;
            shift_d    = mem_q[rd_ptr_q];
            bit_cnt_d  = CW'(DATA_W - 1);
            cur_last_d = mem_last_q[rd_ptr_q];
        end else if (state_q == SHIFT) begin
            shift_d   = {shift_q[DATA_W-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q - CW'(1);
            state_d   = (bit_cnt_q == '0) ? IDLE : SHIFT;
        end
    end

    // State, pointer and shifter registers
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            cur_last_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            cur_last_q <= cur_last_d;
            done_q     <= done_d;
        end
    end

    // FIFO storage; contents need no reset because occupancy is tracked by count_q
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q]      <= res_data;
            mem_last_q[wr_ptr_q] <= res_last;
        end
    end
endmodule

// File: doc/result_serializer.md
Name: result_serializer

Overview:
- Transmit end of the 1-bit result channel (out_valid/out_value) sampled by the lab testbench.
- Accepts parallel DATA_W-bit result words from the datapath into a small FIFO.
- Shifts each word out MSB-first, one bit per cycle, with out_valid high for every bit.
- Flags completion of a result set with a done pulse.

Parameters:
- DATA_W, 20, width of one result word; also the number of serial bits per word.
- DEPTH, 4, FIFO depth in words; must be a power of 2 and at least 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset. Synchronous, active-high: asserted when 1. The port name is retained per codebase convention.
- res_valid  input  1  result word present on res_data / res_last.
- res_data  input  DATA_W  result word.
- res_last  input  1  this word is the final word of the current result set.
- res_ready  output  1  FIFO can accept a word this cycle.
- out_valid  output  1  out_value carries a valid bit.
- out_value  output  1  serial data bit, MSB of each word first.
- done  output  1  one-cycle pulse after the last bit of a res_last word.

Behaviour:
- Reset (rst_n=1 at a rising edge):
  - FIFO emptied, state forced to IDLE, bit counter cleared.
  - out_valid=0, out_value=0, done=0, res_ready=0 during the reset cycle.
  - res_ready=1 from the first cycle after reset deasserts.
  - Reset mid-word aborts the word and discards all buffered words; nothing is replayed.
- Push:
  - Occurs when res_valid && res_ready at a rising edge.
  - res_data and res_last are stored together in FIFO entry [wr_ptr].
  - res_ready = (count < DEPTH), combinational from registered count.
  - A push while full is impossible by construction.
  - res_valid with res_ready=0 is ignored; the source must hold the word.
- Pop:
  - Occurs when the shifter loads a word.
  - Push and pop on the same edge are legal at any occupancy below DEPTH; count stays unchanged.
- FSM states: IDLE, SHIFT.
  - IDLE: if FIFO non-empty, the next edge pops the head into shift_reg, sets bit_cnt=DATA_W-1, and moves to SHIFT.
  - SHIFT: out_valid=1, out_value=shift_reg[DATA_W-1]. Each edge shifts left by 1 and decrements bit_cnt.
  - SHIFT at bit_cnt==0, FIFO non-empty: next edge pops and loads the next word and stays in SHIFT. No gap between words.
  - SHIFT at bit_cnt==0, FIFO empty: next edge returns to IDLE.
- Latency:
  - A word pushed at edge k into an empty FIFO in IDLE has its MSB on out_value after edge k+1.
  - Its LSB appears after edge k+DATA_W.
- out_value is forced to 0 whenever out_valid=0.
- Outputs are registered; no combinational path from res_* to out_*.
- done:
  - Asserted for exactly one cycle: the cycle after the LSB of a word whose stored last flag=1.
  - Coincides with the next word's MSB when words stream back-to-back.
- Pointers: log2(DEPTH)-bit, wrap naturally. count is log2(DEPTH)+1 bits.

Test Plan:
- Single word: reset, then push 20'hA5F3C with last=1 at edge k.
  - out_valid high after edges k+1..k+20.
  - Bits 1010_0101_1111_0011_1100 in order.
  - done=1 only after edge k+21.
  - out_valid=0 and out_value=0 afterwards.
- Back-to-back, 4 words: push 20'h00001, 20'h80000, 20'hFFFFF, 20'h12345 on consecutive cycles, last on the 4th.
  - 80 contiguous out_valid cycles, correct bit order, no gap.
  - res_ready drops for at most the cycles where count==4.
  - One done pulse, after the final bit.
- Full FIFO: hold res_valid=1 with 6 distinct words.
  - Words 5–6 accepted only after pops free entries.
  - Output sequence equals input order; no loss or duplication.
- Simultaneous push/pop: push a word on the exact edge the shifter pops with count==4.
  - Push must wait for res_ready=1. Check res_ready=0 at count==4.
  - When count==3, push+pop on the same edge keeps count==3.
- Reset mid-operation: assert rst_n=1 at bit 7 of word 2 of 3 buffered words.
  - out_valid=0 the cycle after.
  - No done pulse.
  - A fresh word pushed after reset is transmitted normally with MSB-first latency of 1.
- Set boundary: words A (last=1) then B (last=1) streamed back-to-back.
  - done pulses twice, 20 cycles apart.
  - The first pulse coincides with B's MSB.
